gain_offset_clamp_sched: RTL and testbench
==========================================

# gain_offset_clamp_sched

Time-division scheduler that shares one `gain_offset_clamp` engine among `NUM_CH` sample channels. Each channel deposits samples into a one-entry holding slot. A round-robin arbiter issues at most one sample per cycle to the engine, attaching that channel's gain and offset. A channel-tag pipeline matched to the engine latency routes each result back with its channel ID. Per-channel gain/offset are double-buffered: host writes go to shadow registers and become active together on a commit pulse.

## Interface
- `NUM_CH`, 4: number of channels, 2..16.
- `IN_WIDTH`, 8: sample width, signed.
- `GAIN_WIDTH`, 16: gain width, unsigned fixed point.
- `GAIN_RADIX`, 8: gain fractional bits.
- `OFFSET_WIDTH`, 8: offset width, signed.
- `OUT_WIDTH`, 8: result width, signed.
- `PIPE_LATENCY`, 4: engine `in_valid` to `out_valid` latency in cycles.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `ch_valid` in NUM_CH: per-channel sample strobe.
- `ch_in` in NUM_CH*IN_WIDTH: packed samples, channel 0 in the LSBs.
- `cfg_we` in 1: shadow register write strobe.
- `cfg_ch` in $clog2(NUM_CH): channel to write.
- `cfg_gain` in GAIN_WIDTH: shadow gain value.
- `cfg_offset` in OFFSET_WIDTH: shadow offset value.
- `cfg_commit` in 1: copy all shadow registers to the active registers.
- `ovr_clr` in 1: clear `overrun` and `sync_err`.
- `eng_valid` out 1: drives the engine's `in_valid`.
- `eng_in` out IN_WIDTH: drives the engine's `in`.
- `eng_gain` out GAIN_WIDTH: drives the engine's `gain`.
- `eng_offset` out OFFSET_WIDTH: drives the engine's `offset`.
- `eng_out_valid` in 1: engine result valid.
- `eng_out` in OUT_WIDTH: engine result.
- `res_valid` out 1: routed result valid.
- `res_ch` out $clog2(NUM_CH): channel ID of the routed result.
- `res_data` out OUT_WIDTH: routed result.
- `overrun` out NUM_CH: sticky flag, a sample was dropped on that channel.
- `sync_err` out 1: sticky flag, tag/engine mismatch.
- `busy` out 1: a slot is pending or a tag is in flight.
- `stat_ch` in $clog2(NUM_CH): statistics read select.
- `stat_count` out 16: issued-sample count for `stat_ch`.

## Operation
**Capture**
- `ch_valid[i]` high with slot i empty: sample latched; slot pending from the next cycle.
- `ch_valid[i]` high with slot i pending and not granted this cycle: new sample dropped; `overrun[i]` set.
- Slot i granted in the same cycle as `ch_valid[i]`: old sample issued; new sample captured; no overrun.

**Arbitration**
- Round-robin pointer `last` holds the last granted channel.
- Each cycle, grant the first pending channel searching cyclically from `last+1`.
- On a grant: slot cleared, `last` updated.
- No pending channel: `eng_valid`=0; `last` unchanged.

**Issue**
- `eng_*` are registered.
- `eng_gain` and `eng_offset` come from the granted channel's active registers at the grant cycle.

**Configuration**
- `cfg_we` writes the shadow registers of `cfg_ch`; out-of-range `cfg_ch` is ignored.
- `cfg_commit` copies all shadows to the active registers at the clock edge.
- A grant in the same cycle as `cfg_commit` uses the old active values.
- `cfg_we` and `cfg_commit` in the same cycle: the new shadow value is committed.

**Tag pipeline**
- PIPE_LATENCY-deep shift register of {valid, ch}, loaded at issue.
- On `eng_out_valid`:
  - Tail tag valid: `res_valid`=1, `res_ch` = tail ch, `res_data` = `eng_out`, all registered.
  - Tail tag invalid: result discarded. During the first PIPE_LATENCY cycles after reset release this is silent flushing of engine state. Afterwards `sync_err` is set.
- Tail tag valid without `eng_out_valid`: `sync_err` set; tag dropped.

**Clearing**
- `ovr_clr` clears `overrun` and `sync_err`.
- A same-cycle set event wins over `ovr_clr`.

**Reset values**
- Slots empty; `last` = NUM_CH-1, so channel 0 is granted first.
- Shadow and active gain = 1<<GAIN_RADIX (unity); offsets = 0.
- Tags invalid; flush counter = PIPE_LATENCY.
- `eng_valid`, `eng_in`, `eng_gain`, `eng_offset` = 0.
- `res_valid`, `res_ch`, `res_data` = 0.
- `overrun` = 0, `sync_err` = 0, `busy` = 0, `stat_count` = 0.

## Timing
- `ch_valid` in cycle N on an idle block: `eng_valid` in cycle N+2; `res_valid` in cycle N+3+PIPE_LATENCY (N+7 with defaults).
- Sustained throughput: one issue per cycle.
- Each channel is guaranteed one grant per NUM_CH cycles.
- `busy` is registered and falls one cycle after the last result is routed.

## Configuration
- Macro `GOC_SCHED_STATS_EN`.
- Defined:
  - Per-channel 16-bit saturating counters increment on each grant.
  - Counters cleared by reset.
  - `stat_count` is the registered count for `stat_ch`.
- Undefined: no counters are built; `stat_count` is tied to 0.

## Test plan
- Reset, then `ch_valid[2]` with sample 10 at unity gain and offset 0 -> `eng_valid` 2 cycles later; `res_valid` at +7 with `res_ch`=2 and `res_data`=10.
- All 4 channels strobed in the same cycle -> issue order 0,1,2,3 in consecutive cycles. Repeat -> order continues 0,1,2,3 and no starvation.
- `ch_valid[1]` held high for 4 cycles while channels 0, 2 and 3 also stay pending -> `overrun[1]`=1. `ovr_clr` -> `overrun`=0.
- Write channel 0 shadow gain 0x0200, offset 3 -> results keep the old values until `cfg_commit`. Commit in the same cycle as a grant -> that sample uses old values; the next sample gives 2*in+3, clamped to 127 for in=100.
- Engine model injects `eng_out_valid` 2 cycles after reset release -> discarded, `sync_err`=0. The same injection 10 cycles after release -> `sync_err`=1.
- With `GOC_SCHED_STATS_EN` defined, 5 grants to channel 3 -> `stat_count`=5 for `stat_ch`=3. Without the macro -> `stat_count`=0.

Source files
------------

// File: rtl/gain_offset_clamp_sched_if.sv
// Sample, engine and result bus of the gain_offset_clamp scheduler.
// slave = scheduler side, master = sample sources / engine / result sink side.
interface gain_offset_clamp_sched_if #(
  parameter int NUM_CH       = 4,
  parameter int IN_WIDTH     = 8,
  parameter int GAIN_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 8,
  parameter int OUT_WIDTH    = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  // Valid-only, no backpressure: every signal qualified by its *_valid is
  // consumed in the cycle it is high; nothing is held for a ready.
  logic [NUM_CH-1:0]          ch_valid;
  logic [NUM_CH*IN_WIDTH-1:0] ch_in;
  logic                       eng_valid;
  logic [IN_WIDTH-1:0]        eng_in;
  logic [GAIN_WIDTH-1:0]      eng_gain;
  logic [OFFSET_WIDTH-1:0]    eng_offset;
  logic                       eng_out_valid;
  logic [OUT_WIDTH-1:0]       eng_out;
  logic                       res_valid;
  logic [CH_W-1:0]            res_ch;
  logic [OUT_WIDTH-1:0]       res_data;

  modport slave (
    input  ch_valid, ch_in, eng_out_valid, eng_out,
    output eng_valid, eng_in, eng_gain, eng_offset, res_valid, res_ch, res_data
  );

  modport master (
    output ch_valid, ch_in, eng_out_valid, eng_out,
    input  eng_valid, eng_in, eng_gain, eng_offset, res_valid, res_ch, res_data
  );
endinterface

// File: rtl/gain_offset_clamp_sched.sv
// Round-robin time-division scheduler sharing one gain_offset_clamp engine.
// Optional per-channel grant counters are built when GOC_SCHED_STATS_EN is defined.
module gain_offset_clamp_sched #(
  parameter int NUM_CH       = 4,
  parameter int IN_WIDTH     = 8,
  parameter int GAIN_WIDTH   = 16,
  parameter int GAIN_RADIX   = 8,
  parameter int OFFSET_WIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  gain_offset_clamp_sched_if.slave  bus,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [GAIN_WIDTH-1:0]     cfg_gain,
  input  logic [OFFSET_WIDTH-1:0]   cfg_offset,
  input  logic                      cfg_commit,
  input  logic                      ovr_clr,
  output logic [NUM_CH-1:0]         overrun,
  output logic                      sync_err,
  output logic                      busy,
  input  logic [$clog2(NUM_CH)-1:0] stat_ch,
  output logic [15:0]               stat_count
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int FLUSH_W = $clog2(PIPE_LATENCY + 1);
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1 << GAIN_RADIX);

  logic [NUM_CH-1:0]       pend;
  logic [IN_WIDTH-1:0]     slot       [NUM_CH];
  logic [GAIN_WIDTH-1:0]   sh_gain    [NUM_CH];
  logic [GAIN_WIDTH-1:0]   sh_gain_nxt[NUM_CH];
  logic [GAIN_WIDTH-1:0]   act_gain   [NUM_CH];
  logic [OFFSET_WIDTH-1:0] sh_off     [NUM_CH];
  logic [OFFSET_WIDTH-1:0] sh_off_nxt [NUM_CH];
  logic [OFFSET_WIDTH-1:0] act_off    [NUM_CH];
  logic [CH_W-1:0]         last, gnt_ch, cand, eng_ch;
  logic                    gnt_any;
  logic [NUM_CH-1:0]       gnt_vec;
  logic [PIPE_LATENCY-1:0] tag_v;
  logic [CH_W-1:0]         tag_ch     [PIPE_LATENCY];
  logic [FLUSH_W-1:0]      flush;
  logic                    tail_v, set_sync;

  // First pending channel searching cyclically from last+1.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    gnt_vec = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last) + k) % NUM_CH);
      if (!gnt_any && pend[cand]) begin
        gnt_any = 1'b1;
        gnt_ch  = cand;
      end
    end
    gnt_vec[gnt_ch] = gnt_any;
  end

  // Shadow write forwarded so a same-cycle commit picks up the new value.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sh_gain_nxt[i] = sh_gain[i];
      sh_off_nxt[i]  = sh_off[i];
    end
    if (cfg_we && int'(cfg_ch) < NUM_CH) begin
      sh_gain_nxt[cfg_ch] = cfg_gain;
      sh_off_nxt[cfg_ch]  = cfg_offset;
    end
  end

  assign tail_v   = tag_v[PIPE_LATENCY-1];
  assign set_sync = (bus.eng_out_valid && !tail_v && flush == '0) ||
                    (tail_v && !bus.eng_out_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend           <= '0;
      last           <= CH_W'(NUM_CH - 1);
      overrun        <= '0;
      sync_err       <= 1'b0;
      busy           <= 1'b0;
      flush          <= FLUSH_W'(PIPE_LATENCY);
      bus.eng_valid  <= 1'b0;
      bus.eng_in     <= '0;
      bus.eng_gain   <= '0;
      bus.eng_offset <= '0;
      eng_ch         <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_ch     <= '0;
      bus.res_data   <= '0;
      tag_v          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot[i]     <= '0;
        sh_gain[i]  <= UNITY;
        act_gain[i] <= UNITY;
        sh_off[i]   <= '0;
        act_off[i]  <= '0;
      end
      for (int k = 0; k < PIPE_LATENCY; k++) tag_ch[k] <= '0;
    end else begin
      if (ovr_clr) overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_valid[i]) begin
          if (!pend[i] || gnt_vec[i]) begin
            slot[i] <= bus.ch_in[i*IN_WIDTH +: IN_WIDTH];
            pend[i] <= 1'b1;
          end else begin
            overrun[i] <= 1'b1;
          end
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
        sh_gain[i] <= sh_gain_nxt[i];
        sh_off[i]  <= sh_off_nxt[i];
        if (cfg_commit) begin
          act_gain[i] <= sh_gain_nxt[i];
          act_off[i]  <= sh_off_nxt[i];
        end
      end

      bus.eng_valid <= gnt_any;
      if (gnt_any) begin
        bus.eng_in     <= slot[gnt_ch];
        bus.eng_gain   <= act_gain[gnt_ch];
        bus.eng_offset <= act_off[gnt_ch];
        eng_ch         <= gnt_ch;
        last           <= gnt_ch;
      end

      // Tag enters alongside the engine's in_valid, so the tail lines up with out_valid.
      tag_v[0]  <= bus.eng_valid;
      tag_ch[0] <= eng_ch;
      for (int k = 1; k < PIPE_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_ch[k] <= tag_ch[k-1];
      end

      if (flush != '0) flush <= flush - 1'b1;

      bus.res_valid <= bus.eng_out_valid && tail_v;
      if (bus.eng_out_valid && tail_v) begin
        bus.res_ch   <= tag_ch[PIPE_LATENCY-1];
        bus.res_data <= bus.eng_out;
      end

      if (ovr_clr)  sync_err <= 1'b0;
      if (set_sync) sync_err <= 1'b1;

      busy <= (|pend) || bus.eng_valid || (|tag_v);
    end
  end

`ifdef GOC_SCHED_STATS_EN
  logic [15:0] cnt [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (gnt_any && cnt[gnt_ch] != 16'hFFFF) cnt[gnt_ch] <= cnt[gnt_ch] + 16'd1;
      stat_count <= (int'(stat_ch) < NUM_CH) ? cnt[stat_ch] : 16'd0;
    end
  end
`else
  logic stat_unused;
  assign stat_unused = ^stat_ch;
  assign stat_count  = '0;
`endif
endmodule

// File: tb/tb_gain_offset_clamp_sched.sv
// Directed bench for gain_offset_clamp_sched with a 4-cycle engine model and result scoreboard.
module tb_gain_offset_clamp_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_gain = '0;
  logic [7:0]  cfg_offset = '0;
  logic        cfg_commit = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [3:0]  overrun;
  logic        sync_err;
  logic        busy;
  logic [1:0]  stat_ch = '0;
  logic [15:0] stat_count;
  logic        inj = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_eng_cyc = -1;
  int last_res_cyc = -1;
  int rd_idx = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  int          iss_q[$];
  logic [15:0] mg [4];
  logic [7:0]  mo [4];
  logic [3:0]  ep_v;
  logic [7:0]  ep_d [4];

`ifdef GOC_SCHED_STATS_EN
  localparam logic [15:0] STAT_EXP = 16'd5;
`else
  localparam logic [15:0] STAT_EXP = 16'd0;
`endif

  gain_offset_clamp_sched_if #(.NUM_CH(4), .IN_WIDTH(8), .GAIN_WIDTH(16),
                               .OFFSET_WIDTH(8), .OUT_WIDTH(8)) bus ();

  gain_offset_clamp_sched #(
    .NUM_CH(4), .IN_WIDTH(8), .GAIN_WIDTH(16), .GAIN_RADIX(8),
    .OFFSET_WIDTH(8), .OUT_WIDTH(8), .PIPE_LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
    .cfg_commit(cfg_commit), .ovr_clr(ovr_clr),
    .overrun(overrun), .sync_err(sync_err), .busy(busy),
    .stat_ch(stat_ch), .stat_count(stat_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] calc(input logic [7:0] x, input logic [15:0] g, input logic [7:0] o);
    longint p;
    p = (longint'($signed(x)) * longint'(g)) >>> 8;
    p = p + longint'($signed(o));
    if (p > 127) p = 127;
    else if (p < -128) p = -128;
    return p[7:0];
  endfunction

  // engine: registered in_valid -> out_valid after 4 cycles
  always @(posedge clk) begin
    if (rst) begin
      ep_v <= '0;
    end else begin
      ep_v    <= {ep_v[2:0], bus.eng_valid};
      ep_d[0] <= calc(bus.eng_in, bus.eng_gain, bus.eng_offset);
      for (int k = 1; k < 4; k++) ep_d[k] <= ep_d[k-1];
    end
  end
  assign bus.eng_out_valid = ep_v[3] | inj;
  assign bus.eng_out       = inj ? 8'h00 : ep_d[3];

  // monitor
  always @(negedge clk) begin
    if (bus.res_valid) begin
      obs_q.push_back({bus.res_ch, bus.res_data});
      last_res_cyc <= cyc;
    end
    if (bus.eng_valid) begin
      iss_q.push_back(cyc);
      last_eng_cyc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [7:0] x);
    exp_q.push_back({ch, calc(x, mg[ch], mo[ch])});
  endtask

  task automatic strobe(input logic [3:0] m, input logic [7:0] s0, s1, s2, s3);
    bus.ch_valid = m;
    bus.ch_in    = {s3, s2, s1, s0};
    tick();
    bus.ch_valid = '0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ch_valid = '0;
    bus.ch_in    = '0;
    cfg_we       = 1'b0;
    cfg_commit   = 1'b0;
    ovr_clr      = 1'b0;
    inj          = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mg[i] = 16'h0100;
      mo[i] = 8'h00;
    end
    repeat (3) tick();
    chk("rst_eng_valid", 32'(bus.eng_valid), 0);
    chk("rst_eng_gain", 32'(bus.eng_gain), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stat_count", 32'(stat_count), 0);
    rst = 1'b0;
  endtask

  // scoreboard: wait for every expected result, then compare in order
  task automatic drain(input string tag);
    int n;
    int waited;
    n = exp_q.size();
    waited = 0;
    while ((obs_q.size() - rd_idx) < n && waited < 200) begin
      tick();
      waited++;
    end
    repeat (6) tick();
    chk({tag, "_count"}, 32'(obs_q.size() - rd_idx), 32'(n));
    while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
      chk(tag, 32'(obs_q[rd_idx]), 32'(exp_q.pop_front()));
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask

  initial begin
    int n0;
    int i0;
    bus.ch_valid = '0;
    bus.ch_in    = '0;
    do_reset();

    // engine activity while the tag pipeline flushes is silent; later it is an error
    tick();
    tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    tick();
    chk("flush_silent", 32'(sync_err), 0);
    repeat (5) tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    chk("sync_err_set", 32'(sync_err), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("sync_err_clr", 32'(sync_err), 0);

    // single sample latency
    n0 = cyc;
    push_exp(2'd2, 8'd10);
    strobe(4'b0100, 8'd0, 8'd0, 8'd10, 8'd0);
    tick();
    chk("lat_eng_valid", 32'(bus.eng_valid), 1);
    chk("lat_eng_in", 32'(bus.eng_in), 10);
    chk("lat_eng_gain", 32'(bus.eng_gain), 32'h100);
    chk("lat_busy", 32'(busy), 1);
    drain("lat_res");
    chk("lat_eng_cyc", 32'(last_eng_cyc), 32'(n0 + 2));
    chk("lat_res_cyc", 32'(last_res_cyc), 32'(n0 + 7));
    chk("idle_busy", 32'(busy), 0);

    // round robin from reset: 0,1,2,3 back to back, twice
    do_reset();
    repeat (6) tick();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] b;
      b = 8'(r * 4 + 1);
      for (int c = 0; c < 4; c++) push_exp(2'(c), b + 8'(c));
      i0 = iss_q.size();
      strobe(4'hF, b, b + 8'd1, b + 8'd2, b + 8'd3);
      drain("rr_order");
      chk("rr_back_to_back", 32'(iss_q[i0 + 3] - iss_q[i0]), 3);
    end

    // overrun: ch1 held while 0,2,3 pending; grant-cycle capture has no overrun
    push_exp(2'd0, 8'd11);
    push_exp(2'd1, 8'd50);
    push_exp(2'd2, 8'd13);
    push_exp(2'd3, 8'd14);
    push_exp(2'd1, 8'd52);
    bus.ch_valid = 4'hF;
    bus.ch_in    = {8'd14, 8'd13, 8'd50, 8'd11};
    tick();
    bus.ch_valid = 4'b0010;
    bus.ch_in    = {8'd14, 8'd13, 8'd51, 8'd11};
    tick();
    bus.ch_in    = {8'd14, 8'd13, 8'd52, 8'd11};
    tick();
    bus.ch_in    = {8'd14, 8'd13, 8'd53, 8'd11};
    tick();
    bus.ch_valid = '0;
    chk("overrun_set", 32'(overrun), 32'b0010);
    drain("ovr_res");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("overrun_clr", 32'(overrun), 0);

    // shadow write stays inactive until commit
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_gain = 16'h0200; cfg_offset = 8'd3;
    tick();
    cfg_we = 1'b0;
    push_exp(2'd0, 8'd20);
    strobe(4'b0001, 8'd20, 8'd0, 8'd0, 8'd0);
    drain("cfg_shadow");
    push_exp(2'd0, 8'd30);
    strobe(4'b0001, 8'd30, 8'd0, 8'd0, 8'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    mg[0] = 16'h0200;
    mo[0] = 8'd3;
    push_exp(2'd0, 8'd100);
    push_exp(2'd0, 8'hF6);
    strobe(4'b0001, 8'd100, 8'd0, 8'd0, 8'd0);
    strobe(4'b0001, 8'hF6, 8'd0, 8'd0, 8'd0);
    drain("cfg_commit");
    chk("cfg_clamp_model", 32'(calc(8'd100, mg[0], mo[0])), 127);

    // write and commit in one cycle
    cfg_we = 1'b1; cfg_commit = 1'b1; cfg_ch = 2'd1; cfg_gain = 16'h0300; cfg_offset = 8'hFB;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    mg[1] = 16'h0300;
    mo[1] = 8'hFB;
    push_exp(2'd1, 8'd10);
    strobe(4'b0010, 8'd0, 8'd10, 8'd0, 8'd0);
    drain("cfg_we_commit");

    // grant statistics
    do_reset();
    repeat (6) tick();
    for (int k = 0; k < 5; k++) begin
      push_exp(2'd3, 8'(k + 1));
      strobe(4'b1000, 8'd0, 8'd0, 8'd0, 8'(k + 1));
      tick();
    end
    drain("stat_res");
    stat_ch = 2'd3;
    tick();
    tick();
    chk("stat_count_ch3", 32'(stat_count), 32'(STAT_EXP));
    stat_ch = 2'd0;
    tick();
    tick();
    chk("stat_count_ch0", 32'(stat_count), 0);
    chk("final_sync_err", 32'(sync_err), 0);
    chk("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
